adder_error_monitor: RTL and testbench

- Downstream consumer of the 16-bit block carry-speculative approximate adder.
- Takes each operand pair with its approximate sum and carry-out, and recomputes the exact 17-bit sum internally.
- Over a programmed number of samples it accumulates three error metrics: error count, sum of error distances and maximum error distance.
- Used in the characterisation harness to report error rate and mean/maximum error distance for the approximate adder family.

---
 rtl/adder_metrics_pkg.sv | 15 +
 rtl/adder_error_monitor_ed_calc.sv | 16 +
 rtl/adder_error_monitor.sv | 162 ++++++++++++++++
 tb/tb_adder_error_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_metrics_pkg.sv
// Shared definitions for the approximate-adder characterisation monitors:
// run-control state encoding and the default datapath widths.
package adder_metrics_pkg;

   localparam int DATA_W = 16;
   localparam int ED_W   = DATA_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/adder_error_monitor_ed_calc.sv
// Combinational unsigned error distance |exact - approx| plus a flag that is
// high whenever the two results differ.
module ed_calc #(
   parameter int W = adder_metrics_pkg::ED_W
) (
   input  logic [W-1:0] i_exact,
   input  logic [W-1:0] i_approx,
   output logic [W-1:0] o_ed,
   output logic         o_nonzero
);

   // Subtract in whichever order keeps the result non-negative.
   assign o_ed      = (i_exact >= i_approx) ? (i_exact - i_approx) : (i_approx - i_exact);
   assign o_nonzero = (i_exact != i_approx);

endmodule

// File: rtl/adder_error_monitor.sv
// Accumulates error count, summed error distance and maximum error distance
// of an approximate adder against an internally recomputed exact sum.
module adder_error_monitor #(
   parameter int DATA_W = adder_metrics_pkg::DATA_W,
   parameter int CNT_W  = 16,
   parameter int ACC_W  = DATA_W + 1 + CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_samples,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   input  logic [DATA_W-1:0] approx_sum,
   input  logic              approx_cout,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  err_count,
   output logic [DATA_W:0]   max_ed,
   output logic [ACC_W-1:0]  sum_ed
);

   import adder_metrics_pkg::*;

   localparam int EW = DATA_W + 1;

   state_t            r_state;
   logic [CNT_W-1:0]  r_target;
   logic [CNT_W-1:0]  r_accCnt;
   logic              r_inReady;
   logic              r_busy;
   logic              r_done;

   logic              r_s1Valid;
   logic [EW-1:0]     r_s1Exact;
   logic [EW-1:0]     r_s1Approx;
   logic              r_s2Valid;
   logic [EW-1:0]     r_s2Ed;
   logic              r_s2Nz;

   logic [CNT_W-1:0]  r_errCount;
   logic [EW-1:0]     r_maxEd;
   logic [ACC_W-1:0]  r_sumEd;

   logic              w_accept;
   logic              w_start;
   logic [CNT_W-1:0]  w_accNext;
   logic [EW-1:0]     w_exact;
   logic [EW-1:0]     w_ed;
   logic              w_nz;

   assign w_accept  = in_valid & r_inReady;
   assign w_start   = start & ((r_state == IDLE) || (r_state == DONE));
   assign w_accNext = r_accCnt + CNT_W'(1);
   assign w_exact   = {1'b0, a} + {1'b0, b} + EW'(cin);

   // Run control; in_ready is cleared on the accepting edge of the last sample
   // so the block never takes more than num_samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_target  <= '0;
         r_accCnt  <= '0;
         r_inReady <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_target <= num_samples;
                  r_accCnt <= '0;
                  if (num_samples == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= RUN;
                     r_inReady <= 1'b1;
                     r_busy    <= 1'b1;
                     r_done    <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (w_accept) begin
                  r_accCnt <= w_accNext;
                  if (w_accNext == r_target) begin
                     r_inReady <= 1'b0;
                     r_state   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!r_s1Valid && !r_s2Valid) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   ed_calc #(.W(EW)) u_edCalc (
      .i_exact   (r_s1Exact),
      .i_approx  (r_s1Approx),
      .o_ed      (w_ed),
      .o_nonzero (w_nz)
   );

   // Two-stage pipeline: capture results, then register the error distance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid  <= 1'b0;
         r_s1Exact  <= '0;
         r_s1Approx <= '0;
         r_s2Valid  <= 1'b0;
         r_s2Ed     <= '0;
         r_s2Nz     <= 1'b0;
      end else begin
         r_s1Valid <= w_accept;
         if (w_accept) begin
            r_s1Exact  <= w_exact;
            r_s1Approx <= {approx_cout, approx_sum};
         end
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2Ed <= w_ed;
            r_s2Nz <= w_nz;
         end
      end
   end

   // Metric accumulators, cleared by an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_errCount <= '0;
         r_maxEd    <= '0;
         r_sumEd    <= '0;
      end else if (w_start) begin
         r_errCount <= '0;
         r_maxEd    <= '0;
         r_sumEd    <= '0;
      end else if (r_s2Valid) begin
         r_sumEd <= r_sumEd + ACC_W'(r_s2Ed);
         if (r_s2Ed > r_maxEd) r_maxEd <= r_s2Ed;
         if (r_s2Nz) r_errCount <= r_errCount + CNT_W'(1);
      end
   end

   assign in_ready  = r_inReady;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err_count = r_errCount;
   assign max_ed    = r_maxEd;
   assign sum_ed    = r_sumEd;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Randomised scoreboard bench for adder_error_monitor: expected run metrics
// are queued by the stimulus and compared whenever done rises.
module tb_adder_error_monitor;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;
   localparam int ACC_W  = DATA_W + 1 + CNT_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  num_samples = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] a = '0;
   logic [DATA_W-1:0] b = '0;
   logic              cin = 1'b0;
   logic [DATA_W-1:0] approx_sum = '0;
   logic              approx_cout = 1'b0;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  err_count;
   logic [DATA_W:0]   max_ed;
   logic [ACC_W-1:0]  sum_ed;

   typedef struct {
      longint cnt;
      longint mx;
      longint sum;
   } exp_t;

   exp_t   expQ[$];
   int     checks = 0;
   int     failures = 0;
   longint mCnt, mMax, mSum;

   adder_error_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
      .approx_sum(approx_sum), .approx_cout(approx_cout), .busy(busy),
      .done(done), .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
      end
   endtask

   // Monitor: every rising edge of done must match the oldest queued run.
   initial begin
      logic prevDone;
      exp_t e;
      prevDone = 1'b0;
      forever begin
         @(negedge clk);
         if (done && !prevDone) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("err_count", longint'(err_count), e.cnt);
               checkOutput("max_ed", longint'(max_ed), e.mx);
               checkOutput("sum_ed", longint'(sum_ed), e.sum);
            end
         end
         prevDone = done;
      end
   end

   task automatic applyStimulus(input int n);
      start = 1'b1;
      num_samples = CNT_W'(n);
      @(posedge clk); #1;
      start = 1'b0;
      mCnt = 0; mMax = 0; mSum = 0;
   endtask

   // Presents one sample until accepted, then folds it into the model.
   task automatic sendSample(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                             input logic [15:0] vs, input logic vco);
      int guard;
      longint ex, ap, ed;
      guard = 0;
      a = va; b = vb; cin = vc; approx_sum = vs; approx_cout = vco;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      ex = longint'(va) + longint'(vb) + longint'(vc);
      ap = longint'(vco) * 65536 + longint'(vs);
      ed = (ex > ap) ? ex - ap : ap - ex;
      mSum += ed;
      if (ed > mMax) mMax = ed;
      if (ed != 0) mCnt++;
   endtask

   task automatic sendRandom(input int mode);
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] ex, ap;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      ex = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      case (mode)
         0:       ap = ex;
         1:       ap = ex ^ (17'd1 << $urandom_range(0, 16));
         default: ap = 17'($urandom);
      endcase
      sendSample(ra, rb, rc, ap[15:0], ap[16]);
   endtask

   task automatic pushExpected();
      exp_t e;
      e.cnt = mCnt; e.mx = mMax; e.sum = mSum;
      expQ.push_back(e);
   endtask

   task automatic waitDone(input string name);
      int k;
      k = 0;
      while (!done && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (!done) checkOutput(name, 0, 1);
      @(negedge clk);
   endtask

   initial begin
      int k;
      $display("[TB] start");
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_done", longint'(done), 0);
      checkOutput("reset_busy", longint'(busy), 0);
      checkOutput("reset_in_ready", longint'(in_ready), 0);

      // Reset mid-run abandons the run.
      applyStimulus(8);
      checkOutput("run_busy", longint'(busy), 1);
      for (int i = 0; i < 3; i++) sendRandom(2);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", longint'(busy), 0);
      checkOutput("midreset_in_ready", longint'(in_ready), 0);
      checkOutput("midreset_err_count", longint'(err_count), 0);
      checkOutput("midreset_max_ed", longint'(max_ed), 0);
      checkOutput("midreset_sum_ed", longint'(sum_ed), 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(2);
      sendRandom(1); sendRandom(2);
      pushExpected();
      waitDone("done_after_reset");

      // Exact-match run.
      applyStimulus(4);
      sendSample(16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0);
      for (int i = 0; i < 3; i++) sendRandom(0);
      pushExpected();
      waitDone("done_exact");
      checkOutput("exact_err_count", longint'(err_count), 0);

      // Speculation miss with known distances.
      applyStimulus(2);
      sendSample(16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b0);
      sendSample(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
      pushExpected();
      waitDone("done_miss");
      checkOutput("miss_sum_ed", longint'(sum_ed), 64'h10010);
      checkOutput("miss_max_ed", longint'(max_ed), 64'h10000);

      // Zero-length run from DONE clears metrics and finishes at once.
      applyStimulus(0);
      checkOutput("zero_done", longint'(done), 1);
      checkOutput("zero_sum_ed", longint'(sum_ed), 0);
      checkOutput("zero_max_ed", longint'(max_ed), 0);
      checkOutput("zero_err_count", longint'(err_count), 0);

      // Handshake gaps: valid toggles, check in_ready drop and done latency.
      applyStimulus(3);
      for (int i = 0; i < 3; i++) begin
         if (i != 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         sendRandom(2);
      end
      pushExpected();
      checkOutput("gap_in_ready_drop", longint'(in_ready), 0);
      k = 0;
      while (!done && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      checkOutput("gap_done_latency", longint'(k), 3);
      @(negedge clk);

      // Start pulses in RUN and DRAIN are ignored.
      applyStimulus(4);
      sendRandom(1); sendRandom(2);
      start = 1'b1; num_samples = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      sendRandom(1); sendRandom(2);
      pushExpected();
      start = 1'b1; num_samples = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("drain_start_in_ready", longint'(in_ready), 0);
      waitDone("done_ignored_start");

      // Randomised runs with random valid gaps.
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 24);
         applyStimulus(n);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
            sendRandom($urandom_range(0, 2));
         end
         pushExpected();
         waitDone("done_random");
      end

      k = 0;
      while (expQ.size() != 0 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      checkOutput("scoreboard_drained", longint'(expQ.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
